// File: rtl/ring_osc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_pkg
//  Description : Shared types and defaults for the ring-oscillator meter:
//                sequencer state encoding, default settle/sync depths and a
//                small width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ring_osc_pkg;

  // Sequencer states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } ro_state_t;

  // Default number of clk cycles the ring runs before counting begins
  localparam int RO_SETTLE_DEF = 8;

  // Default depth of the osc_in synchronizer
  localparam int RO_SYNC_DEF = 2;

  // Larger of two integers; used to size the shared phase timer
  function automatic int ro_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : ring_osc_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-flop synchronizer for an asynchronous input followed
//                by a rising-edge detector. The pulse is one clk wide and is
//                derived purely from flopped values.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the async input through the chain; keep one extra flop of history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/ring_osc_meter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_meter
//  Description : Measurement sequencer for the on-chip ring oscillator.
//                Enables the ring, lets it settle, counts synchronized rising
//                edges over a programmable window, drains the synchronizer,
//                then reports a saturating count with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_osc_meter
  import ring_osc_pkg::*;
#(
  parameter int WINDOW_W    = 16,
  parameter int CNT_W       = 16,
  parameter int SETTLE      = RO_SETTLE_DEF,
  parameter int SYNC_STAGES = RO_SYNC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WINDOW_W-1:0] window,
  input  logic                osc_in,
  output logic                osc_en,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                overflow
);

  // One down-counter serves SETTLE, MEASURE and DRAIN, so it must hold the
  // largest of the three reload values.
  localparam int PH_W  = $clog2(SETTLE + SYNC_STAGES + 2);
  localparam int TMR_W = ro_max(WINDOW_W, PH_W);

  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  ro_state_t           state;
  ro_state_t           state_nxt;
  logic [TMR_W-1:0]    tmr;
  logic [TMR_W-1:0]    tmr_nxt;
  logic [WINDOW_W-1:0] win_q;
  logic                rise;
  logic                accept;
  logic                count_en;
  logic                active;

  // Ring output enters the clk domain here
  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (osc_in),
    .rise  (rise)
  );

  assign accept   = (state == ST_IDLE) && start;
  assign count_en = (state == ST_MEASURE) || (state == ST_DRAIN);
  assign active   = (state == ST_SETTLE) || (state == ST_MEASURE) ||
                    (state == ST_DRAIN);

  // Next-state and phase-timer logic; abort overrides any phase exit
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (window == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_SETTLE;
            tmr_nxt   = SETTLE_LD;
          end
        end
      end
      ST_SETTLE: begin
        if (tmr == '0) begin
          state_nxt = ST_MEASURE;
          tmr_nxt   = TMR_W'(win_q) - TMR_ONE;
        end else begin
          tmr_nxt = tmr - TMR_ONE;
        end
      end
      ST_MEASURE: begin
        if (tmr == '0) begin
          state_nxt = ST_DRAIN;
          tmr_nxt   = DRAIN_LD;
        end else begin
          tmr_nxt = tmr - TMR_ONE;
        end
      end
      ST_DRAIN: begin
        if (tmr == '0) begin
          state_nxt = ST_DONE;
        end else begin
          tmr_nxt = tmr - TMR_ONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort && active) begin
      state_nxt = ST_IDLE;
    end
  end

  // State register plus outputs registered from the next state so they
  // line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      tmr    <= '0;
      osc_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tmr    <= tmr_nxt;
      osc_en <= (state_nxt == ST_SETTLE) || (state_nxt == ST_MEASURE);
      busy   <= (state_nxt == ST_SETTLE) || (state_nxt == ST_MEASURE) ||
                (state_nxt == ST_DRAIN);
      done   <= (state_nxt == ST_DONE);
    end
  end

  // Window length is frozen at the accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (accept) begin
      win_q <= window;
    end
  end

  // Saturating edge counter; overflow flags an edge lost at full scale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (count_en && rise) begin
      if (count == CNT_MAX) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CNT_ONE;
      end
    end
  end

endmodule : ring_osc_meter
`default_nettype wire

// File: tb/tb_ring_osc_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_osc_meter
//  Description : Directed self-checking bench for ring_osc_meter. A default
//                instance and a 4-bit-counter instance share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_osc_meter;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        abort  = 1'b0;
  logic        osc_in = 1'b0;
  logic [15:0] window = '0;

  logic        osc_en, busy, done, overflow;
  logic [15:0] count;
  logic        osc_en4, busy4, done4, overflow4;
  logic [3:0]  count4;

  int          n_checks = 0;
  int          n_errors = 0;
  int          osc_mode = 0;
  logic [31:0] ph = '0;

  ring_osc_meter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .window   (window),
    .osc_in   (osc_in),
    .osc_en   (osc_en),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .overflow (overflow)
  );

  ring_osc_meter #(
    .CNT_W (4)
  ) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .window   (window),
    .osc_in   (osc_in),
    .osc_en   (osc_en4),
    .busy     (busy4),
    .done     (done4),
    .count    (count4),
    .overflow (overflow4)
  );

  always #5 clk = ~clk;

  // Ring model: period 4 clk (mode 1) or 2 clk (mode 2), edges off the clk edge
  initial begin
    forever begin
      @(posedge clk);
      #3;
      ph = ph + 1;
      case (osc_mode)
        1:       osc_in = ph[1];
        2:       osc_in = ph[0];
        default: osc_in = 1'b0;
      endcase
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns 1 time unit after the accepting edge
  task automatic launch(input logic [15:0] w);
    @(posedge clk);
    #1;
    start  = 1'b1;
    window = w;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycles (1 = first cycle after the accepting edge) until done; 0 on timeout
  task automatic wait_done(input int max_cyc, output int lat, output logic en_seen,
                           output logic busy_seen);
    lat       = 0;
    en_seen   = 1'b0;
    busy_seen = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (osc_en) en_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  int   lat;
  logic en_seen, busy_seen;

  initial begin
    // Reset with the ring toggling
    osc_mode = 1;
    repeat (3) @(negedge clk);
    check("rst_osc_en", osc_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Period 4, W=100: done at 112, 25 +/- 1 edges
    launch(16'd100);
    wait_done(200, lat, en_seen, busy_seen);
    check("p4_latency", lat, 112);
    check("p4_count_in_range", (count >= 16'd24 && count <= 16'd26), 1);
    check("p4_overflow", overflow, 0);
    check("p4_en_seen", en_seen, 1);
    @(negedge clk);
    check("p4_done_one_cycle", done, 0);
    check("p4_idle_osc_en", osc_en, 0);

    // Period 2 into the 4-bit instance: saturates at 15 with overflow
    osc_mode = 2;
    launch(16'd100);
    wait_done(200, lat, en_seen, busy_seen);
    check("p2_latency", lat, 112);
    check("sat_count", count4, 15);
    check("sat_overflow", overflow4, 1);
    check("p2_wide_no_overflow", overflow, 0);

    // W=0: done next cycle, nothing enabled, clears previous result
    osc_mode = 1;
    launch(16'd0);
    wait_done(10, lat, en_seen, busy_seen);
    check("w0_latency", lat, 1);
    check("w0_osc_en_never", en_seen, 0);
    check("w0_busy_never", busy_seen, 0);
    check("w0_count", count, 0);
    check("w0_sat_count_cleared", count4, 0);
    check("w0_sat_overflow_cleared", overflow4, 0);
    repeat (2) @(negedge clk);

    // Abort in MEASURE cycle 5
    launch(16'd100);
    repeat (12) @(negedge clk);
    check("abort_pre_osc_en", osc_en, 1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_osc_en", osc_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    wait_done(150, lat, en_seen, busy_seen);
    check("abort_no_done", lat, 0);
    check("abort_stays_idle", busy_seen, 0);
    launch(16'd100);
    wait_done(200, lat, en_seen, busy_seen);
    check("post_abort_latency", lat, 112);
    check("post_abort_count_in_range", (count >= 16'd24 && count <= 16'd26), 1);

    // Start pulsed while busy is ignored
    repeat (2) @(negedge clk);
    launch(16'd100);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (i == 30) begin
        start  = 1'b1;
        window = 16'd5;
      end
      if (i == 32) begin
        start  = 1'b0;
        window = 16'd100;
      end
    end
    check("busy_start_latency", lat, 112);
    check("busy_start_count_in_range", (count >= 16'd24 && count <= 16'd26), 1);

    // Start held high: back-to-back runs with one IDLE cycle between
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    start  = 1'b1;
    window = 16'd20;
    @(posedge clk);
    #1;
    wait_done(100, lat, en_seen, busy_seen);
    check("held_first_latency", lat, 32);
    @(negedge clk);
    check("held_idle_busy", busy, 0);
    check("held_idle_osc_en", osc_en, 0);
    @(negedge clk);
    check("held_relaunch_osc_en", osc_en, 1);
    check("held_relaunch_busy", busy, 1);
    wait_done(100, lat, en_seen, busy_seen);
    start = 1'b0;
    check("held_second_latency", lat, 31);
    repeat (3) @(negedge clk);

    // Reset mid-MEASURE: osc_en drops immediately, no done afterwards
    launch(16'd100);
    repeat (50) @(negedge clk);
    check("rstmid_pre_osc_en", osc_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_osc_en", osc_en, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_count", count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_done(150, lat, en_seen, busy_seen);
    check("rstmid_no_done", lat, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ring_osc_meter
`default_nettype wire

// File: doc/ring_osc_meter.md
# ring_osc_meter

Measurement sequencer for the on-chip inverter-chain ring oscillator. It drives the ring's enable, lets the ring settle, and counts ring-output rising edges over a programmable window of system clocks. It then presents the count with a done pulse. It sits between the top-level pin wrapper, which supplies `start`/`window` from switches or a host, and the ring, whose enable it owns and whose output it samples.

## Interface
- `WINDOW_W`, 16: width of the measurement-window length, in clk cycles
- `CNT_W`, 16: width of the edge counter
- `SETTLE`, 8: clk cycles the ring runs before counting starts; must be ≥1
- `SYNC_STAGES`, 2: flops in the `osc_in` synchronizer; must be ≥2

- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, asynchronous active-low reset
- `start`  in  1  level; sampled only in IDLE; launches a measurement
- `abort`  in  1  level; cancels a measurement in progress
- `window`  in  WINDOW_W  measurement length in clk cycles; captured at start
- `osc_in`  in  1  ring output; asynchronous to clk
- `osc_en`  out  1  ring enable; registered
- `busy`  out  1  high from the cycle after start is accepted until the done cycle, exclusive
- `done`  out  1  one-cycle pulse; `count` is valid
- `count`  out  CNT_W  rising edges counted in the last completed window
- `overflow`  out  1  counter saturated during the last window

## Operation
- FSM states: IDLE, SETTLE, MEASURE, DRAIN, DONE.
- IDLE, on start=1:
  - Capture `window` into `win_q`.
  - Clear `count` and `overflow`.
  - Go to SETTLE.
  - Exception: if `window`==0, go straight to DONE. `osc_en` is never asserted and `count` is 0.
- SETTLE: `osc_en`=1 for SETTLE cycles. No counting. Then go to MEASURE.
- MEASURE: `osc_en`=1 for `win_q` cycles. Then go to DRAIN.
- DRAIN:
  - `osc_en`=0 for SYNC_STAGES+1 cycles.
  - Counting stays enabled so that edges still in the synchronizer are counted.
  - Then go to DONE.
- Counting is enabled in MEASURE and DRAIN. The counted window is therefore exactly `win_q` cycles long, shifted by the synchronizer latency.
- Edge detect:
  - `osc_in` passes through SYNC_STAGES flops.
  - A rising edge is `sync_q & ~sync_prev`.
  - One detected edge increments `count` by 1.
- Saturation: at 2^CNT_W−1, `count` holds and `overflow` is set. `overflow` stays set until the next accepted start.
- DONE: `done`=1 and `busy`=0 for one cycle, then go to IDLE. `count` and `overflow` hold until the next accepted start.
- `start` in any state other than IDLE is ignored. `start` held high re-launches on the first IDLE cycle after DONE.
- `abort`=1 in SETTLE, MEASURE or DRAIN:
  - Next state is IDLE and `osc_en`=0 next cycle.
  - `done` is never pulsed.
  - `count` holds the partial value and is marked invalid by the absence of `done`.
  - `abort` has priority over a same-cycle state transition.
- Reset mid-operation clears everything immediately (asynchronous). The ring stops because `osc_en` drops.
- A ring disabled by `osc_en`=0 settles low (even inversion count). Shutdown therefore never creates a rising edge.
- Measurable ring frequency is below clk/2. Faster rings alias and are out of scope.

## Timing
- Reset values:
  - State IDLE.
  - `osc_en`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0.
  - All synchronizer flops 0.
- Start accepted at edge k gives:
  - `busy`=1 and `osc_en`=1 from cycle k+1.
  - MEASURE during cycles k+1+SETTLE through k+SETTLE+W.
  - DRAIN during the next SYNC_STAGES+1 cycles.
  - `done` at cycle k+1+SETTLE+W+SYNC_STAGES+1.
  - With default parameters, latency is W+12 cycles.
- W=0: `done` at cycle k+1 and `busy` stays 0.
- Count accuracy: ±1 edge, due to window-to-phase alignment.

## Structure
- Package `ring_osc_pkg`:
  - state enum `ro_state_t` (IDLE, SETTLE, MEASURE, DRAIN, DONE)
  - default constants `RO_SETTLE_DEF`=8 and `RO_SYNC_DEF`=2
- Sub-module `sync_edge_det` (parameter `STAGES`): synchronizer chain plus rising-edge pulse. It is reused wherever `osc_in` is sampled.
- Top: FSM, window down-counter, saturating edge counter.

## Test plan
- Reset with `osc_in` toggling: all outputs 0 and `osc_en`=0. `rst_n` low mid-MEASURE gives `osc_en`=0 in the same cycle with no `done`.
- `osc_in` period 4 clk, W=100, defaults: `done` exactly 112 cycles after start, `count`=25±1, `overflow`=0.
- `osc_in` period 2 clk, CNT_W=4, W=100: `count`=15 and `overflow`=1. The next start clears both.
- W=0: `done` the cycle after start, `count`=0, `osc_en` never high.
- `abort` in cycle 5 of MEASURE: `osc_en`=0 the next cycle, no `done`, state IDLE. A new start runs a full measurement normally.
- `start` pulsed while busy: ignored, with `done` timing unchanged. `start` held high: back-to-back measurements with one IDLE cycle between DONE and the next SETTLE.
